// File: rtl/ram_dump_if.sv
// Write-stream and dump handshake bundle for ram_dump_module.
// The slave side is the dump module; the master side is the upstream/consumer.
interface ram_dump_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              write_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              start_sig;
    logic              done_sig;
    logic              dump_busy;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_written;
    logic [DATA_W-1:0] checksum;
    logic [ADDR_W:0]   written_cnt;

    modport slave (
        input  write_en, ram_addr, ram_data, start_sig,
        output done_sig, dump_busy, dump_valid, dump_addr, dump_data,
               dump_written, checksum, written_cnt
    );

    modport master (
        output write_en, ram_addr, ram_data, start_sig,
        input  done_sig, dump_busy, dump_valid, dump_addr, dump_data,
               dump_written, checksum, written_cnt
    );
endinterface

// File: rtl/ram_dump_module.sv
// Captures the ROM-to-RAM write stream into a small RAM with a written bitmap,
// and on request streams every entry back out with a checksum and entry count.
module ram_dump_module #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_dump_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  wbit_q;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              vld_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              wr_q;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;

    logic [DATA_W-1:0] beat_data;

    assign beat_data = wr_q ? rdata_q : '0;

    // Read samples mem before this edge's write lands: read-before-write on collision.
    always_ff @(posedge clk) begin
        if (bus.write_en) begin
            mem[bus.ram_addr] <= bus.ram_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            wbit_q    <= '0;
            vld_q     <= 1'b0;
            addr_q    <= '0;
            rdata_q   <= '0;
            wr_q      <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            wcnt_q    <= wcnt_d;
            vld_q     <= (state_q == READ);
            if (bus.write_en) begin
                wbit_q[bus.ram_addr] <= 1'b1;
            end
            if (state_q == READ) begin
                addr_q  <= rd_addr_q;
                rdata_q <= mem[rd_addr_q];
                wr_q    <= wbit_q[rd_addr_q];
            end else begin
                wr_q    <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        wcnt_d    = wcnt_q;

        if (vld_q && wr_q) begin
            acc_d = acc_q + beat_data;
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start_sig) begin
                    state_d   = READ;
                    rd_addr_d = '0;
                    acc_d     = '0;
                    cnt_d     = '0;
                end
            end
            READ: begin
                if (rd_addr_q == '1) begin
                    state_d = DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // Fold in the last beat here so results are visible alongside done_sig.
                state_d = DONE;
                sum_d   = acc_d;
                wcnt_d  = cnt_d;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.done_sig     = (state_q == DONE);
    assign bus.dump_busy    = (state_q != IDLE);
    assign bus.dump_valid   = vld_q;
    assign bus.dump_addr    = addr_q;
    assign bus.dump_data    = beat_data;
    assign bus.dump_written = wr_q;
    assign bus.checksum     = sum_q;
    assign bus.written_cnt  = wcnt_q;
endmodule

// File: tb/tb_ram_dump_module.sv
// Directed bench for ram_dump_module: scenario table of writes and expected
// dump results, plus hand-written collision, ignored-start and reset sequences.
module tb_ram_dump_module;
    logic clk;
    logic rst_n;

    ram_dump_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    ram_dump_module #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0]  mask;
        logic [127:0] data;
        logic [7:0]   exp_sum;
        logic [4:0]   exp_cnt;
    } scen_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.write_en  = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_data  = '0;
        bus.start_sig = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.write_en = 1'b1;
        bus.ram_addr = a;
        bus.ram_data = d;
        tick();
        bus.write_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".done"},    32'(bus.done_sig),     32'd0);
        chk({tag, ".busy"},    32'(bus.dump_busy),    32'd0);
        chk({tag, ".valid"},   32'(bus.dump_valid),   32'd0);
        chk({tag, ".addr"},    32'(bus.dump_addr),    32'd0);
        chk({tag, ".data"},    32'(bus.dump_data),    32'd0);
        chk({tag, ".written"}, 32'(bus.dump_written), 32'd0);
        chk({tag, ".sum"},     32'(bus.checksum),     32'd0);
        chk({tag, ".cnt"},     32'(bus.written_cnt),  32'd0);
    endtask

    // Start sampled in cycle 0; cycle c is the c-th cycle after. Optional write
    // injected at coll_cyc and spurious start at dup_cyc (0 = none).
    task automatic run_dump(input string tag, input logic [15:0] mask, input logic [127:0] data,
                            input logic [7:0] esum, input logic [4:0] ecnt,
                            input int coll_cyc, input logic [3:0] ca, input logic [7:0] cd,
                            input int dup_cyc);
        logic [7:0] ed;
        bus.start_sig = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            bus.write_en  = (c == coll_cyc);
            bus.ram_addr  = ca;
            bus.ram_data  = cd;
            bus.start_sig = (c == dup_cyc);
            if (c == 1) begin
                chk({tag, ".busy1"},  32'(bus.dump_busy),  32'd1);
                chk({tag, ".valid1"}, 32'(bus.dump_valid), 32'd0);
            end else if (c <= 17) begin
                ed = mask[c-2] ? data[(c-2)*8 +: 8] : 8'h00;
                chk({tag, ".valid"},   32'(bus.dump_valid),   32'd1);
                chk({tag, ".addr"},    32'(bus.dump_addr),    32'(c-2));
                chk({tag, ".written"}, 32'(bus.dump_written), 32'(mask[c-2]));
                chk({tag, ".data"},    32'(bus.dump_data),    32'(ed));
                chk({tag, ".done"},    32'(bus.done_sig),     32'd0);
            end else if (c == 18) begin
                chk({tag, ".done18"},  32'(bus.done_sig),    32'd1);
                chk({tag, ".valid18"}, 32'(bus.dump_valid),  32'd0);
                chk({tag, ".busy18"},  32'(bus.dump_busy),   32'd1);
                chk({tag, ".sum"},     32'(bus.checksum),    32'(esum));
                chk({tag, ".cnt"},     32'(bus.written_cnt), 32'(ecnt));
            end else begin
                chk({tag, ".done19"}, 32'(bus.done_sig),    32'd0);
                chk({tag, ".busy19"}, 32'(bus.dump_busy),   32'd0);
                chk({tag, ".sumhold"}, 32'(bus.checksum),   32'(esum));
            end
        end
        bus.write_en  = 1'b0;
        bus.start_sig = 1'b0;
    endtask

    scen_t tbl [5];
    logic [127:0] d;

    initial begin
        // Scenario table: writes applied after a reset, then one dump.
        tbl[0] = '{mask: 16'h0000, data: '0, exp_sum: 8'h00, exp_cnt: 5'd0};
        for (int k = 0; k < 16; k++) d[k*8 +: 8] = 8'(8'h10 + k);
        tbl[1] = '{mask: 16'hFFFF, data: d, exp_sum: 8'h78, exp_cnt: 5'd16};
        d = '0; d[3*8 +: 8] = 8'hFF; d[9*8 +: 8] = 8'h02;
        tbl[2] = '{mask: 16'h0208, data: d, exp_sum: 8'h01, exp_cnt: 5'd2};
        d = '0; d[0 +: 8] = 8'h80; d[15*8 +: 8] = 8'h80;
        tbl[3] = '{mask: 16'h8001, data: d, exp_sum: 8'h00, exp_cnt: 5'd2};
        d = '0; for (int k = 1; k < 16; k += 2) d[k*8 +: 8] = 8'h01;
        tbl[4] = '{mask: 16'hAAAA, data: d, exp_sum: 8'h08, exp_cnt: 5'd8};

        do_reset();
        chk_all_zero("por");

        for (int i = 0; i < 5; i++) begin
            do_reset();
            for (int k = 0; k < 16; k++)
                if (tbl[i].mask[k]) wr(4'(k), tbl[i].data[k*8 +: 8]);
            run_dump($sformatf("scen%0d", i), tbl[i].mask, tbl[i].data,
                     tbl[i].exp_sum, tbl[i].exp_cnt, 0, 4'd0, 8'h00, 0);
        end

        // Overwrite, then collision on addr5 at issue cycle (c=6) with a
        // spurious start at c=5 that must be ignored.
        do_reset();
        wr(4'd5, 8'h77);
        wr(4'd5, 8'h11);
        d = '0; d[5*8 +: 8] = 8'h11;
        run_dump("coll1", 16'h0020, d, 8'h11, 5'd1, 6, 4'd5, 8'hAA, 5);
        tick();
        chk("nostart.busy", 32'(bus.dump_busy), 32'd0);
        chk("nostart.done", 32'(bus.done_sig),  32'd0);
        d[5*8 +: 8] = 8'hAA;
        run_dump("coll2", 16'h0020, d, 8'hAA, 5'd1, 0, 4'd0, 8'h00, 0);

        // Mid-dump reset clears everything, including the bitmap.
        bus.start_sig = 1'b1;
        tick();
        bus.start_sig = 1'b0;
        repeat (7) tick();
        chk("pre_rst.valid", 32'(bus.dump_valid), 32'd1);
        chk("pre_rst.addr",  32'(bus.dump_addr),  32'd6);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        run_dump("postrst", 16'h0000, '0, 8'h00, 5'd0, 0, 4'd0, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
